// File: rtl/hazard_pkg.sv
// Shared types for the multi-cycle hazard unit.
// Forward-select encoding and multiplier occupancy states.
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_t;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mul_state_t;

endpackage

// File: rtl/hazard_unit_mc_mul_occupancy_fsm.sv
// Multiplier occupancy tracker: holds E for MUL_LAT cycles.
// Ports: clk, reset_n, start, freeze in; mul (stall), busy out.
module mul_occupancy_fsm
  import hazard_pkg::*;
#(
  parameter int MUL_LAT = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic start,
  input  logic freeze,
  output logic mul,
  output logic busy
);

  localparam int CW =
    (MUL_LAT > 2) ? $clog2(MUL_LAT) : 1;
  localparam logic [CW-1:0] LOAD =
    CW'(MUL_LAT - 2);

  mul_state_t     state;
  mul_state_t     state_nx;
  logic [CW-1:0]  cnt;
  logic [CW-1:0]  cnt_nx;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

  // The start cycle itself stalls; BUSY then covers the
  // remaining cycles, the last of which releases the stall.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    mul      = 1'b0;
    unique case (state)
      IDLE: begin
        mul = start;
        if (start && !freeze) begin
          state_nx = BUSY;
          cnt_nx   = LOAD;
        end
      end
      BUSY: begin
        mul = (cnt != '0);
        if (!freeze) begin
          if (cnt != '0)
            cnt_nx = cnt - CW'(1);
          else
            state_nx = IDLE;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  assign busy = (state == BUSY);

endmodule

// File: rtl/hazard_unit_mc.sv
// Hazard unit: forwarding, stall/flush, multiplier and memory waits.
// Ports: per-stage regs/enables in; forward, stall, flush, counters out.
module hazard_unit_mc
  import hazard_pkg::*;
#(
  parameter int REG_W   = 5,
  parameter int MUL_LAT = 4,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [REG_W-1:0] rs_d,
  input  logic [REG_W-1:0] rt_d,
  input  logic [REG_W-1:0] rs_e,
  input  logic [REG_W-1:0] rt_e,
  input  logic [REG_W-1:0] write_reg_e,
  input  logic [REG_W-1:0] write_reg_m,
  input  logic [REG_W-1:0] write_reg_w,
  input  logic             reg_write_e,
  input  logic             reg_write_m,
  input  logic             reg_write_w,
  input  logic             mem_to_reg_e,
  input  logic             mem_to_reg_m,
  input  logic             branch_d,
  input  logic             mul_start_e,
  input  logic             mem_req_m,
  input  logic             mem_ready_m,
  output logic [1:0]       forward_ae,
  output logic [1:0]       forward_be,
  output logic             forward_ad,
  output logic             forward_bd,
  output logic             stall_f,
  output logic             stall_d,
  output logic             stall_e,
  output logic             stall_m,
  output logic             flush_e,
  output logic             flush_m,
  output logic             flush_w,
  output logic             mul_busy,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] lw_stall_cnt
);

  // r0 is hardwired zero, so it never creates a dependency.
  function automatic logic hit(
    input logic [REG_W-1:0] a,
    input logic [REG_W-1:0] b
  );
    return (a != '0) && (a == b);
  endfunction

  function automatic fwd_sel_t fwd(
    input logic [REG_W-1:0] src
  );
    if (reg_write_m && hit(src, write_reg_m))
      return FWD_MEM;
    else if (reg_write_w && hit(src, write_reg_w))
      return FWD_WB;
    else
      return FWD_RF;
  endfunction

  fwd_sel_t fae;
  fwd_sel_t fbe;
  logic     fad;
  logic     fbd;
  logic     dep_e;
  logic     dep_m;
  logic     lw;
  logic     br;
  logic     mem;
  logic     mul;
  logic     sf;

  assign fae = fwd(rs_e);
  assign fbe = fwd(rt_e);
  assign fad = reg_write_m && hit(rs_d, write_reg_m);
  assign fbd = reg_write_m && hit(rt_d, write_reg_m);

  assign dep_e = hit(write_reg_e, rs_d)
              || hit(write_reg_e, rt_d);
  assign dep_m = hit(write_reg_m, rs_d)
              || hit(write_reg_m, rt_d);

  assign lw  = mem_to_reg_e && reg_write_e && dep_e;
  assign br  = branch_d
            && ((reg_write_e && dep_e)
             || (mem_to_reg_m && dep_m));
  assign mem = mem_req_m && !mem_ready_m;

  mul_occupancy_fsm #(
    .MUL_LAT (MUL_LAT)
  ) u_mul (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (mul_start_e),
    .freeze  (mem),
    .mul     (mul),
    .busy    (mul_busy)
  );

  assign sf = lw | br | mul | mem;

  // Controls are held inactive for the whole reset window,
  // not just from the next clock edge.
  assign forward_ae = reset_n ? fae : FWD_RF;
  assign forward_be = reset_n ? fbe : FWD_RF;
  assign forward_ad = reset_n & fad;
  assign forward_bd = reset_n & fbd;
  assign stall_f    = reset_n & sf;
  assign stall_d    = reset_n & sf;
  assign stall_e    = reset_n & (mul | mem);
  assign stall_m    = reset_n & mem;
  assign flush_e    = reset_n & (lw | br) & !mul & !mem;
  assign flush_m    = reset_n & mul & !mem;
  assign flush_w    = reset_n & mem;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt    <= '0;
      lw_stall_cnt <= '0;
    end else begin
      if (sf && (stall_cnt != '1))
        stall_cnt <= stall_cnt + CNT_W'(1);
      if (lw && !mul && !mem && (lw_stall_cnt != '1))
        lw_stall_cnt <= lw_stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_unit_mc.sv
// Directed vector bench for hazard_unit_mc.
// Combinational table plus multi-cycle sequences.
module tb_hazard_unit_mc;

  logic       clk = 1'b0;
  logic       reset_n;
  logic [4:0] rs_d, rt_d, rs_e, rt_e;
  logic [4:0] write_reg_e, write_reg_m, write_reg_w;
  logic       reg_write_e, reg_write_m, reg_write_w;
  logic       mem_to_reg_e, mem_to_reg_m, branch_d;
  logic       mul_start_e, mem_req_m, mem_ready_m;
  logic [1:0] forward_ae, forward_be;
  logic       forward_ad, forward_bd;
  logic       stall_f, stall_d, stall_e, stall_m;
  logic       flush_e, flush_m, flush_w, mul_busy;
  logic [3:0] stall_cnt, lw_stall_cnt;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  hazard_unit_mc #(
    .REG_W   (5),
    .MUL_LAT (4),
    .CNT_W   (4)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .rs_d         (rs_d),
    .rt_d         (rt_d),
    .rs_e         (rs_e),
    .rt_e         (rt_e),
    .write_reg_e  (write_reg_e),
    .write_reg_m  (write_reg_m),
    .write_reg_w  (write_reg_w),
    .reg_write_e  (reg_write_e),
    .reg_write_m  (reg_write_m),
    .reg_write_w  (reg_write_w),
    .mem_to_reg_e (mem_to_reg_e),
    .mem_to_reg_m (mem_to_reg_m),
    .branch_d     (branch_d),
    .mul_start_e  (mul_start_e),
    .mem_req_m    (mem_req_m),
    .mem_ready_m  (mem_ready_m),
    .forward_ae   (forward_ae),
    .forward_be   (forward_be),
    .forward_ad   (forward_ad),
    .forward_bd   (forward_bd),
    .stall_f      (stall_f),
    .stall_d      (stall_d),
    .stall_e      (stall_e),
    .stall_m      (stall_m),
    .flush_e      (flush_e),
    .flush_m      (flush_m),
    .flush_w      (flush_w),
    .mul_busy     (mul_busy),
    .stall_cnt    (stall_cnt),
    .lw_stall_cnt (lw_stall_cnt)
  );

  typedef struct {
    logic [4:0] rs_d, rt_d, rs_e, rt_e;
    logic [4:0] wre, wrm, wrw;
    logic [7:0] ctl;
    logic [1:0] fae, fbe;
    logic [7:0] exp;
  } vec_t;

  vec_t v[17];

  // ctl: rwe rwm rww mte mtm br mreq mrdy
  // exp: fad fbd sf se sm fe fm fw
  function automatic vec_t mk(
    input logic [4:0] a, b, c, d, e, m, w,
    input logic [7:0] ctl,
    input logic [1:0] fae, fbe,
    input logic [7:0] exp
  );
    vec_t x;
    x.rs_d = a; x.rt_d = b;
    x.rs_e = c; x.rt_e = d;
    x.wre = e; x.wrm = m; x.wrw = w;
    x.ctl = ctl;
    x.fae = fae; x.fbe = fbe;
    x.exp = exp;
    return x;
  endfunction

  task automatic chk(input string nm,
                     input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d",
               nm, act, req);
    end
  endtask

  task automatic idle();
    rs_d = 0; rt_d = 0; rs_e = 0; rt_e = 0;
    write_reg_e = 0; write_reg_m = 0; write_reg_w = 0;
    reg_write_e = 0; reg_write_m = 0; reg_write_w = 0;
    mem_to_reg_e = 0; mem_to_reg_m = 0; branch_d = 0;
    mul_start_e = 0; mem_req_m = 0; mem_ready_m = 0;
  endtask

  task automatic apply(input vec_t x);
    rs_d = x.rs_d; rt_d = x.rt_d;
    rs_e = x.rs_e; rt_e = x.rt_e;
    write_reg_e = x.wre;
    write_reg_m = x.wrm;
    write_reg_w = x.wrw;
    {reg_write_e, reg_write_m, reg_write_w,
     mem_to_reg_e, mem_to_reg_m, branch_d,
     mem_req_m, mem_ready_m} = x.ctl;
    mul_start_e = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    idle();
    reset_n = 0;
    #2;
    reset_n = 1;
  endtask

  // Every output should be quiet; used under reset.
  task automatic chk_quiet(input string nm);
    chk({nm, "_fwd"},
        {forward_ae, forward_be, forward_ad, forward_bd}, 0);
    chk({nm, "_stall"},
        {stall_f, stall_d, stall_e, stall_m}, 0);
    chk({nm, "_flush"}, {flush_e, flush_m, flush_w}, 0);
    chk({nm, "_busy"}, mul_busy, 0);
    chk({nm, "_cnt"}, stall_cnt, 0);
    chk({nm, "_lwcnt"}, lw_stall_cnt, 0);
  endtask

  initial begin
    v[0]  = mk(0, 0, 3, 0, 0, 3, 3, 8'b01100000, 2, 0, 8'h00);
    v[1]  = mk(0, 0, 3, 0, 0, 3, 3, 8'b00100000, 1, 0, 8'h00);
    v[2]  = mk(0, 0, 0, 0, 0, 0, 0, 8'b01100000, 0, 0, 8'h00);
    v[3]  = mk(0, 0, 4, 9, 0, 9, 4, 8'b01100000, 1, 2, 8'h00);
    v[4]  = mk(0, 5, 0, 0, 5, 0, 0, 8'b10010000, 0, 0,
               8'b00100100);
    v[5]  = mk(0, 0, 0, 0, 0, 0, 0, 8'b10010000, 0, 0, 8'h00);
    v[6]  = mk(0, 5, 0, 0, 5, 0, 0, 8'b00010000, 0, 0, 8'h00);
    v[7]  = mk(7, 0, 0, 0, 0, 7, 0, 8'b00001100, 0, 0,
               8'b00100100);
    v[8]  = mk(7, 0, 0, 0, 0, 7, 0, 8'b01000100, 0, 0,
               8'b10000000);
    v[9]  = mk(0, 6, 0, 0, 6, 0, 0, 8'b10000100, 0, 0,
               8'b00100100);
    v[10] = mk(0, 6, 0, 0, 6, 0, 0, 8'b10000000, 0, 0, 8'h00);
    v[11] = mk(0, 0, 0, 0, 0, 0, 0, 8'b00000010, 0, 0,
               8'b00111001);
    v[12] = mk(0, 5, 0, 0, 5, 0, 0, 8'b10010010, 0, 0,
               8'b00111001);
    v[13] = mk(0, 0, 0, 0, 0, 0, 0, 8'b00000011, 0, 0, 8'h00);
    v[14] = mk(0, 12, 0, 0, 0, 12, 0, 8'b01000000, 0, 0,
               8'b01000000);
    v[15] = mk(0, 0, 0, 0, 0, 0, 0, 8'b00001100, 0, 0, 8'h00);
    v[16] = mk(0, 0, 8, 0, 0, 0, 8, 8'b00000000, 0, 0, 8'h00);

    // Reset state with inputs that would otherwise fire.
    idle();
    reset_n = 0;
    rs_e = 3; write_reg_m = 3; reg_write_m = 1;
    mem_req_m = 1; branch_d = 1; rs_d = 3;
    mem_to_reg_m = 1;
    #1;
    chk_quiet("rst");
    @(negedge clk);
    idle();
    reset_n = 1;

    // Combinational table, one clock per vector.
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      apply(v[i]);
      #1;
      chk($sformatf("v%0d_fae", i), forward_ae, v[i].fae);
      chk($sformatf("v%0d_fbe", i), forward_be, v[i].fbe);
      chk($sformatf("v%0d_ctl", i),
          {forward_ad, forward_bd, stall_f, stall_e,
           stall_m, flush_e, flush_m, flush_w}, v[i].exp);
      chk($sformatf("v%0d_sd", i), stall_d, v[i].exp[5]);
    end
    @(negedge clk);
    idle();
    #1;
    chk("tbl_stall_cnt", stall_cnt, 5);
    chk("tbl_lw_cnt", lw_stall_cnt, 1);

    // Load-use counter step 0 -> 1.
    do_reset();
    @(negedge clk);
    chk("lu_cnt0", lw_stall_cnt, 0);
    mem_to_reg_e = 1; reg_write_e = 1;
    write_reg_e = 5; rt_d = 5;
    #1;
    chk("lu_se", stall_e, 0);
    chk("lu_fe", flush_e, 1);
    @(negedge clk);
    idle();
    #1;
    chk("lu_cnt1", lw_stall_cnt, 1);
    chk("lu_release", stall_f, 0);

    // Two back-to-back multiplies.
    do_reset();
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      mul_start_e = 1;
      #1;
      chk($sformatf("mul%0d_se", k), stall_e, (k % 4) < 3);
      chk($sformatf("mul%0d_fm", k), flush_m, (k % 4) < 3);
      chk($sformatf("mul%0d_sf", k), stall_f, (k % 4) < 3);
      chk($sformatf("mul%0d_busy", k), mul_busy,
          (k % 4) >= 1);
    end
    @(negedge clk);
    mul_start_e = 0;
    #1;
    chk("mul_idle", mul_busy, 0);
    chk("mul_cnt", stall_cnt, 6);

    // Memory wait freezing the multiplier at cnt=1.
    begin
      bit mr[6] = '{0, 0, 1, 1, 0, 0};
      bit fm[6] = '{1, 1, 0, 0, 1, 0};
      bit bz[6] = '{0, 1, 1, 1, 1, 1};
      bit sf[6] = '{1, 1, 1, 1, 1, 0};
      do_reset();
      for (int k = 0; k < 6; k++) begin
        @(negedge clk);
        mul_start_e = 1;
        mem_req_m = mr[k];
        mem_ready_m = 0;
        #1;
        chk($sformatf("mw%0d_fm", k), flush_m, fm[k]);
        chk($sformatf("mw%0d_sm", k), stall_m, mr[k]);
        chk($sformatf("mw%0d_fw", k), flush_w, mr[k]);
        chk($sformatf("mw%0d_busy", k), mul_busy, bz[k]);
        chk($sformatf("mw%0d_sf", k), stall_f, sf[k]);
      end
      @(negedge clk);
      idle();
      #1;
      chk("mw_idle", mul_busy, 0);
      chk("mw_cnt", stall_cnt, 5);
    end

    // Reset in the middle of BUSY.
    do_reset();
    @(negedge clk);
    mul_start_e = 1;
    @(negedge clk);
    #1;
    chk("mr_busy", mul_busy, 1);
    chk("mr_cnt_pre", stall_cnt, 1);
    #1;
    reset_n = 0;
    rs_e = 3; write_reg_m = 3; reg_write_m = 1;
    mem_req_m = 1;
    #1;
    chk_quiet("mr");
    @(negedge clk);
    idle();
    mul_start_e = 1;
    reset_n = 1;
    #1;
    chk("mr_post_busy", mul_busy, 0);
    chk("mr_post_se", stall_e, 1);
    @(negedge clk);
    #1;
    chk("mr_post_busy2", mul_busy, 1);

    // Counter saturation at 4 bits.
    do_reset();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      mem_req_m = 1;
      mem_ready_m = 0;
      #1;
      if (i == 15) chk("sat_15", stall_cnt, 15);
    end
    @(negedge clk);
    idle();
    #1;
    chk("sat_20", stall_cnt, 15);

    do_reset();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      mem_to_reg_e = 1; reg_write_e = 1;
      write_reg_e = 4; rs_d = 4;
    end
    @(negedge clk);
    idle();
    #1;
    chk("lw_sat", lw_stall_cnt, 15);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/hazard_unit_mc.md
Name: hazard_unit_mc

Overview:
- Parametrised successor to the single-cycle pipeline hazard unit for the 5-stage MIPS core (F/D/E/M/W).
- Adds four capabilities:
  - decode-stage branch forwarding;
  - multi-cycle execute-unit (multiplier) occupancy tracking via an FSM;
  - variable-latency data-memory wait handshake;
  - saturating performance counters for stall cycles.
- Sits beside the datapath and drives all forward-select, stall and flush controls.

Parameters:
- REG_W, 5, register index width.
- MUL_LAT, 4, cycles a multiply occupies E (legal range 2..16).
- CNT_W, 16, width of the performance counters.

Ports:
- clk  in  1  pipeline clock.
- reset_n  in  1  asynchronous active-low reset.
- rs_d, rt_d  in  REG_W  source registers in D.
- rs_e, rt_e  in  REG_W  source registers in E.
- write_reg_e, write_reg_m, write_reg_w  in  REG_W  destination registers per stage.
- reg_write_e, reg_write_m, reg_write_w  in  1  register-write enables per stage.
- mem_to_reg_e, mem_to_reg_m  in  1  stage holds a load.
- branch_d  in  1  branch being resolved in D.
- mul_start_e  in  1  multiply present in E.
- mem_req_m  in  1  M-stage memory access active.
- mem_ready_m  in  1  memory completes access this cycle.
- forward_ae, forward_be  out  2  E operand select: 00 register file, 01 W, 10 M.
- forward_ad, forward_bd  out  1  D branch comparator takes the M-stage ALU result.
- stall_f, stall_d, stall_e, stall_m  out  1  hold the pipeline register.
- flush_e, flush_m, flush_w  out  1  insert a bubble into the stage.
- mul_busy  out  1  FSM is in BUSY.
- stall_cnt  out  CNT_W  cycles with stall_f asserted.
- lw_stall_cnt  out  CNT_W  cycles attributed to load-use stalls.

Behaviour:
- Register 0 never matches in any comparison.
- Forwarding (combinational):
  - forward_ae = 10 if rs_e==write_reg_m && reg_write_m; else 01 if rs_e==write_reg_w && reg_write_w; else 00.
  - forward_be uses the same rule with rt_e.
  - forward_ad = rs_d==write_reg_m && reg_write_m. forward_bd uses the same rule with rt_d.
- Stall conditions:
  - lw = mem_to_reg_e && reg_write_e && write_reg_e∈{rs_d,rt_d}.
  - br = branch_d && ((reg_write_e && write_reg_e∈{rs_d,rt_d}) || (mem_to_reg_m && write_reg_m∈{rs_d,rt_d})).
  - mem = mem_req_m && !mem_ready_m.
- Multiplier FSM, states IDLE and BUSY, with down-counter cnt:
  - IDLE & mul_start_e: mul = 1; next state BUSY; cnt <= MUL_LAT-2.
  - BUSY: mul = (cnt!=0). If cnt!=0, decrement; at cnt==0 go to IDLE, ignoring mul_start_e (same instruction).
  - Result: MUL_LAT cycles in E, MUL_LAT-1 stall cycles. A back-to-back multiply is accepted on the next IDLE cycle.
  - While mem=1 the FSM and cnt hold their values (frozen).
- Output composition:
  - stall_f = stall_d = lw|br|mul|mem.
  - stall_e = mul|mem.
  - stall_m = mem.
  - flush_e = (lw|br) & !mul & !mem.
  - flush_m = mul & !mem.
  - flush_w = mem.
- Counters:
  - stall_cnt increments when stall_f=1.
  - lw_stall_cnt increments when lw & !mul & !mem.
  - Both saturate at all-ones (no wrap).
- Reset:
  - While reset_n=0: FSM IDLE, cnt=0, counters=0, and every stall, flush and forward output forced to 0.
  - Reset asserted mid-multiply aborts the multiply immediately. The first cycle after deassertion behaves as IDLE.

Decomposition:
- Shared package hazard_pkg holds:
  - fwd_sel_t enum: FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10;
  - mul_state_t enum: IDLE, BUSY.
- Sub-module mul_occupancy_fsm: FSM plus cnt. Inputs: start, freeze. Outputs: mul stall, busy.
- Forwarding, stall composition and counters stay in the top level.

Test Plan:
- Forward priority: rs_e=3, write_reg_m=3/reg_write_m=1, write_reg_w=3/reg_write_w=1 -> forward_ae=10. Drop reg_write_m -> 01. rs_e=0 -> 00.
- Load-use: mem_to_reg_e=1, reg_write_e=1, write_reg_e=5, rt_d=5 -> one cycle of stall_f=stall_d=flush_e=1, stall_e=0. lw_stall_cnt goes 0->1.
- Branch: branch_d=1, rs_d=7, mem_to_reg_m=1, write_reg_m=7 -> stall_d=flush_e=1. Next cycle with mem_to_reg_m=0, reg_write_m=1 -> forward_ad=1 and no stall.
- Multiply, MUL_LAT=4: mul_start_e held high for 4 cycles -> stall_e=flush_m=1 for 3 cycles, mul_busy high on cycles 2-4, released on cycle 4. An immediate second multiply produces another 3 stall cycles.
- Memory wait during BUSY: mem_ready_m=0 for 2 cycles with mem_req_m=1 while cnt=1 -> stall_m=flush_w=1, flush_m=0, cnt holds at 1. Total multiply stall cycles stay at 3. stall_cnt counts all 5 cycles.
- Reset_n pulsed low mid-BUSY -> all outputs 0 asynchronously, counters 0, FSM back to IDLE. With CNT_W=4, 20 stall cycles -> stall_cnt=15 (saturates).
